aq_sigcap_trig: RTL and testbench

Parametrised single-clock logic-analyser capture engine with an internal ring buffer. It samples a qualified `DATA_W`-bit bus into a 2^`ADDR_W`-deep ring. It triggers on a programmable level or edge condition and keeps a programmable number of post-trigger samples. Results are read back over the AQ local bus. It sits beside the other local-bus peripherals and supersedes the dual-clock/external-RAM capture controller wherever capture data is synchronous to the bus clock.

---
 rtl/aq_sigcap_trig_if.sv | 37 +++
 rtl/aq_sigcap_trig.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_aq_sigcap_trig.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_sigcap_trig_if.sv
`default_nettype none
// ============================================================================
// Module   : aq_sigcap_trig_if
// Brief    : AQ local-bus signal bundle for the signal-capture trigger engine.
//            The master drives the request and the slave returns ACK/RDATA.
// Revision : 1.0  initial release
// ============================================================================
interface aq_sigcap_trig_if;
    logic        AQ_LOCAL_CS;
    logic        AQ_LOCAL_RNW;
    logic        AQ_LOCAL_ACK;
    logic [15:0] AQ_LOCAL_ADDR;
    logic [3:0]  AQ_LOCAL_BE;
    logic [31:0] AQ_LOCAL_WDATA;
    logic [31:0] AQ_LOCAL_RDATA;

    modport master (
        output AQ_LOCAL_CS,
        output AQ_LOCAL_RNW,
        output AQ_LOCAL_ADDR,
        output AQ_LOCAL_BE,
        output AQ_LOCAL_WDATA,
        input  AQ_LOCAL_ACK,
        input  AQ_LOCAL_RDATA
    );

    modport slave (
        input  AQ_LOCAL_CS,
        input  AQ_LOCAL_RNW,
        input  AQ_LOCAL_ADDR,
        input  AQ_LOCAL_BE,
        input  AQ_LOCAL_WDATA,
        output AQ_LOCAL_ACK,
        output AQ_LOCAL_RDATA
    );
endinterface
`default_nettype wire

// File: rtl/aq_sigcap_trig.sv
`default_nettype none
// ============================================================================
// Module   : aq_sigcap_trig
// Brief    : Single-clock logic-analyser capture engine. Qualified samples are
//            written into a 2^ADDR_W ring; a level/edge/forced trigger plus a
//            post-trigger count ends the capture. Registers and the ring are
//            read back over the AQ local bus.
// Revision : 1.0  initial release
// ============================================================================
module aq_sigcap_trig #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  wire logic              CLK,
    input  wire logic              RST_N,
    aq_sigcap_trig_if.slave        bus,
    input  wire logic [DATA_W-1:0] CAP_DATA,
    input  wire logic              CAP_VALID,
    output logic                   IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Configuration and status
    logic [ADDR_W-1:0] post_cnt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] value;
    logic [2:0]        mode;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] tptr;
    logic [ADDR_W-1:0] remain;
    logic              done;
    logic              wrapped;
    logic              first;

    // Sample pipeline
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] prev;
    logic              vflag;

    // Ring buffer
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_q;

    // Bus decode
    logic [3:0]  region;
    logic [7:0]  offset;
    logic        wr_en;
    logic        reg_wr;
    logic        ctl_wr;
    logic        start_req;
    logic        abort_req;
    logic        rd_start;
    logic        rd_busy;
    logic        rd_buf;
    logic        ack_rd;
    logic [31:0] rdata_q;
    logic [31:0] reg_rdata;
    logic [ADDR_W-1:0] buf_idx;

    // FSM side effects
    logic arm;
    logic store;
    logic trig;

    // Trigger conditions
    logic lvl_hit;
    logic rise_hit;
    logic fall_hit;
    logic chg_hit;
    logic cond_hit;
    logic hit;

    // Bits that carry no function (byte enables, sub-word address, high data)
    logic unused_bits;
    assign unused_bits = ^{bus.AQ_LOCAL_BE, bus.AQ_LOCAL_ADDR[1:0],
                           bus.AQ_LOCAL_ADDR[11:8], bus.AQ_LOCAL_WDATA};

    assign region    = bus.AQ_LOCAL_ADDR[15:12];
    assign offset    = {bus.AQ_LOCAL_ADDR[7:2], 2'b00};
    assign buf_idx   = bus.AQ_LOCAL_ADDR[ADDR_W+1:2];
    assign wr_en     = bus.AQ_LOCAL_CS & ~bus.AQ_LOCAL_RNW;
    assign reg_wr    = wr_en & (region == 4'd0);
    assign ctl_wr    = reg_wr & (offset == 8'h00);
    // Abort takes precedence when both control bits are written together
    assign abort_req = ctl_wr & bus.AQ_LOCAL_WDATA[1];
    assign start_req = ctl_wr & bus.AQ_LOCAL_WDATA[0] & ~bus.AQ_LOCAL_WDATA[1];
    assign rd_start  = bus.AQ_LOCAL_CS & bus.AQ_LOCAL_RNW & ~rd_busy;

    assign bus.AQ_LOCAL_ACK   = ack_rd | wr_en;
    assign bus.AQ_LOCAL_RDATA = rdata_q;
    assign IRQ                = done;

    // Masked trigger conditions; edge modes are blind on the first sample
    assign lvl_hit  = ((cur & mask) == (value & mask));
    assign rise_hit = |(cur & ~prev & mask);
    assign fall_hit = |(~cur & prev & mask);
    assign chg_hit  = |((cur ^ prev) & mask);

    // Select the trigger condition for the programmed mode
    always_comb begin
        cond_hit = 1'b0;
        case (mode[1:0])
            2'd0:    cond_hit = lvl_hit;
            2'd1:    cond_hit = rise_hit & ~first;
            2'd2:    cond_hit = fall_hit & ~first;
            default: cond_hit = chg_hit & ~first;
        endcase
        hit = cond_hit | mode[2];
    end

    // Register the qualified sample and keep the previous one for edge modes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur   <= '0;
            prev  <= '0;
            vflag <= 1'b0;
        end else begin
            vflag <= CAP_VALID;
            if (CAP_VALID) begin
                cur  <= CAP_DATA;
                prev <= cur;
            end
        end
    end

    // Capture state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and capture side effects
    always_comb begin
        state_nx = state;
        arm      = 1'b0;
        store    = 1'b0;
        trig     = 1'b0;
        if (abort_req) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_req) begin
                        arm      = 1'b1;
                        state_nx = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (vflag) begin
                        store = 1'b1;
                        if (hit) begin
                            trig     = 1'b1;
                            state_nx = (post_cnt == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                default: begin
                    if (vflag) begin
                        store = 1'b1;
                        if (remain == ADDR_W'(1)) begin
                            state_nx = ST_DONE;
                        end
                    end
                end
            endcase
        end
    end

    // Configuration registers, pointers and capture flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            post_cnt <= '0;
            mask     <= '0;
            value    <= '0;
            mode     <= '0;
            wptr     <= '0;
            tptr     <= '0;
            remain   <= '0;
            done     <= 1'b0;
            wrapped  <= 1'b0;
            first    <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (offset)
                    8'h04:   post_cnt <= bus.AQ_LOCAL_WDATA[ADDR_W-1:0];
                    8'h08:   mask     <= bus.AQ_LOCAL_WDATA[DATA_W-1:0];
                    8'h0C:   value    <= bus.AQ_LOCAL_WDATA[DATA_W-1:0];
                    8'h10:   mode     <= bus.AQ_LOCAL_WDATA[2:0];
                    default: ;
                endcase
            end
            if (arm) begin
                wptr    <= '0;
                wrapped <= 1'b0;
                done    <= 1'b0;
                first   <= 1'b1;
            end
            if (abort_req) begin
                done <= 1'b0;
            end
            if (store) begin
                wptr  <= wptr + ADDR_W'(1);
                first <= 1'b0;
                if (wptr == '1) begin
                    wrapped <= 1'b1;
                end
            end
            if (trig) begin
                tptr   <= wptr;
                remain <= post_cnt;
            end else if (store) begin
                remain <= remain - ADDR_W'(1);
            end
            if ((state_nx == ST_DONE) && (state != ST_DONE)) begin
                done <= 1'b1;
            end
        end
    end

    // Ring buffer write port and synchronous read port
    always_ff @(posedge CLK) begin
        if (store) begin
            mem[wptr] <= cur;
        end
        ram_q <= mem[buf_idx];
    end

    // Register readback mux; anything outside the register page reads 0
    always_comb begin
        reg_rdata = '0;
        if (region == 4'd0) begin
            case (offset)
                8'h00:   reg_rdata = {done, wrapped, 28'd0, state};
                8'h04:   reg_rdata = 32'(post_cnt);
                8'h08:   reg_rdata = 32'(mask);
                8'h0C:   reg_rdata = 32'(value);
                8'h10:   reg_rdata = 32'(mode);
                8'h14:   reg_rdata = 32'(wptr);
                8'h18:   reg_rdata = 32'(tptr);
                default: reg_rdata = '0;
            endcase
        end
    end

    // Read sequencing: one cycle for registers, two for the ring buffer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_busy <= 1'b0;
            rd_buf  <= 1'b0;
            ack_rd  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_rd <= 1'b0;
            if (rd_start) begin
                rd_busy <= 1'b1;
                if (region == 4'd1) begin
                    rd_buf <= 1'b1;
                end else begin
                    ack_rd  <= 1'b1;
                    rdata_q <= reg_rdata;
                end
            end else if (rd_buf) begin
                rd_buf  <= 1'b0;
                ack_rd  <= 1'b1;
                rdata_q <= 32'(ram_q);
            end else if (ack_rd) begin
                rd_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aq_sigcap_trig.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_sigcap_trig
// Brief    : Self-checking bench for aq_sigcap_trig (DATA_W=8, ADDR_W=4).
//            Expected read data is queued at issue time and popped by a
//            separate monitor on every read acknowledge.
// Revision : 1.0  initial release
// ============================================================================
module tb_aq_sigcap_trig;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] addr;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] cap_data;
    logic          cap_valid;
    logic          irq;

    aq_sigcap_trig_if bus ();

    aq_sigcap_trig #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bus.slave),
        .CAP_DATA  (cap_data),
        .CAP_VALID (cap_valid),
        .IRQ       (irq)
    );

    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    // Reference model state
    logic [DW-1:0] stream[$];
    logic [DW-1:0] mmem [DEPTH];
    bit            mknown [DEPTH];
    int            exp_wptr;
    int            exp_tptr;
    int            exp_state;
    bit            exp_wrap;
    bit            exp_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read acknowledge consumes one expectation
    always @(negedge clk) begin
        if (bus.AQ_LOCAL_ACK && bus.AQ_LOCAL_CS && bus.AQ_LOCAL_RNW) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h expected no ack", bus.AQ_LOCAL_RDATA);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_%04h", e.addr), bus.AQ_LOCAL_RDATA, e.data);
            end
        end
    end

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        bus.AQ_LOCAL_CS    = 1'b1;
        bus.AQ_LOCAL_RNW   = 1'b0;
        bus.AQ_LOCAL_ADDR  = a;
        bus.AQ_LOCAL_WDATA = d;
        bus.AQ_LOCAL_BE    = 4'hF;
        @(negedge clk);
        chk("wr_ack", 32'(bus.AQ_LOCAL_ACK), 32'd1);
        @(posedge clk);
        #1;
        bus.AQ_LOCAL_CS = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] e, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        exp_q.push_back('{data: e, addr: a});
        bus.AQ_LOCAL_CS   = 1'b1;
        bus.AQ_LOCAL_RNW  = 1'b1;
        bus.AQ_LOCAL_ADDR = a;
        while (!got && lat <= 8) begin
            @(negedge clk);
            if (bus.AQ_LOCAL_ACK) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk($sformatf("lat_%04h", a), 32'(lat), 32'(exp_lat));
        if (!got) begin
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk);
            #1;
        end
        bus.AQ_LOCAL_CS  = 1'b0;
        bus.AQ_LOCAL_RNW = 1'b0;
        @(negedge clk);
        chk("ack_len", 32'(bus.AQ_LOCAL_ACK), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // gap < 0 selects a random 0..2 idle cycles between samples
    task automatic send_stream(input int gap);
        for (int i = 0; i < stream.size(); i++) begin
            cap_valid = 1'b1;
            cap_data  = stream[i];
            @(posedge clk);
            #1;
            cap_valid = 1'b0;
            repeat ((gap < 0) ? int'($urandom_range(2, 0)) : gap) begin
                @(posedge clk);
                #1;
            end
        end
        cap_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit model_hit(input int i, input logic [1:0] md, input bit frc,
                                     input logic [DW-1:0] mk, input logic [DW-1:0] vl);
        logic [DW-1:0] c;
        logic [DW-1:0] p;
        c = stream[i];
        p = (i > 0) ? stream[i-1] : '0;
        if (frc) return 1'b1;
        case (md)
            2'd0:    return (c & mk) == (vl & mk);
            2'd1:    return (i > 0) && ((c & ~p & mk) != 0);
            2'd2:    return (i > 0) && ((~c & p & mk) != 0);
            default: return (i > 0) && (((c ^ p) & mk) != 0);
        endcase
    endfunction

    // Derive the capture result from the list of samples seen after start
    task automatic model_capture(input logic [1:0] md, input bit frc, input logic [DW-1:0] mk,
                                 input logic [DW-1:0] vl, input int post);
        int t;
        int cnt;
        t = -1;
        for (int i = 0; i < stream.size(); i++) begin
            if (model_hit(i, md, frc, mk, vl)) begin
                t = i;
                break;
            end
        end
        if (t < 0) begin
            cnt       = stream.size();
            exp_state = 1;
        end else if (stream.size() - 1 >= t + post) begin
            cnt       = t + post + 1;
            exp_state = 3;
        end else begin
            cnt       = stream.size();
            exp_state = 2;
        end
        for (int k = 0; k < cnt; k++) begin
            mmem[k % DEPTH]   = stream[k];
            mknown[k % DEPTH] = 1'b1;
        end
        if (t >= 0) exp_tptr = t % DEPTH;
        exp_wptr = cnt % DEPTH;
        exp_wrap = (cnt >= DEPTH);
        exp_done = (exp_state == 3);
    endtask

    task automatic check_all();
        bus_read(16'h0000, {exp_done, exp_wrap, 28'd0, 2'(exp_state)}, 1);
        bus_read(16'h0014, 32'(exp_wptr), 1);
        bus_read(16'h0018, 32'(exp_tptr), 1);
        chk("irq", 32'(irq), 32'(exp_done));
        for (int k = 0; k < DEPTH; k++) begin
            if (mknown[k]) bus_read(16'h1000 + 16'(k * 4), 32'(mmem[k]), 2);
        end
    endtask

    task automatic capture(input logic [1:0] md, input bit frc, input logic [DW-1:0] mk,
                           input logic [DW-1:0] vl, input int post, input int gap);
        bus_write(16'h0000, 32'd2);
        bus_write(16'h0004, 32'(post));
        bus_write(16'h0008, 32'(mk));
        bus_write(16'h000C, 32'(vl));
        bus_write(16'h0010, {29'd0, frc, md});
        bus_read(16'h0004, 32'(post % DEPTH), 1);
        bus_read(16'h0010, {29'd0, frc, md}, 1);
        bus_write(16'h0000, 32'd1);
        send_stream(gap);
        model_capture(md, frc, mk, vl, post % DEPTH);
        check_all();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_wptr  = 0;
        exp_tptr  = 0;
        exp_state = 0;
        exp_wrap  = 1'b0;
        exp_done  = 1'b0;
        for (int k = 0; k < DEPTH; k++) mknown[k] = 1'b0;
        bus.AQ_LOCAL_CS    = 1'b0;
        bus.AQ_LOCAL_RNW   = 1'b0;
        bus.AQ_LOCAL_ADDR  = '0;
        bus.AQ_LOCAL_BE    = '0;
        bus.AQ_LOCAL_WDATA = '0;
        cap_data  = '0;
        cap_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state of every register
        for (int a = 0; a <= 24; a += 4) bus_read(16'(a), 32'd0, 1);
        chk("irq_reset", 32'(irq), 32'd0);

        // Level trigger on a ramp that wraps the 16-entry ring
        stream.delete();
        for (int i = 0; i < 80; i++) stream.push_back(DW'(i));
        capture(2'd0, 1'b0, 8'hFF, 8'h40, 3, 0);
        chk("ramp_oldest", 32'(mmem[exp_wptr]), 32'h34);

        // Rising edge: bit0 high from the first sample, fresh edge at index 5
        stream.delete();
        foreach (stream[i]) stream.delete(i);
        stream.push_back(8'h01); stream.push_back(8'h01); stream.push_back(8'h01);
        stream.push_back(8'h01); stream.push_back(8'h00); stream.push_back(8'h01);
        stream.push_back(8'h01); stream.push_back(8'h01);
        capture(2'd1, 1'b0, 8'h01, 8'h00, 2, 0);

        // Forced trigger, no post samples, valid every other cycle
        stream.delete();
        for (int i = 0; i < 6; i++) stream.push_back(DW'($urandom));
        capture(2'd0, 1'b1, 8'h00, 8'h00, 0, 1);

        // Abort while in POST, then start+abort, then a clean start
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(DW'($urandom));
        capture(2'd0, 1'b1, 8'h00, 8'h00, 10, 0);
        bus_write(16'h0000, 32'd2);
        exp_state = 0;
        exp_done  = 1'b0;
        check_all();
        bus_write(16'h0000, 32'd3);
        check_all();
        bus_write(16'h0000, 32'd1);
        exp_state = 1;
        exp_wptr  = 0;
        exp_wrap  = 1'b0;
        check_all();

        // Address decode outside the register set
        bus_read(16'h001C, 32'd0, 1);
        bus_read(16'h0080, 32'd0, 1);
        bus_read(16'h2000, 32'd0, 1);
        bus_read(16'h3004, 32'd0, 1);

        // Randomised captures across all modes
        for (int n = 0; n < 10; n++) begin
            int len;
            logic [1:0] md;
            bit frc;
            logic [DW-1:0] mk;
            logic [DW-1:0] vl;
            len = int'($urandom_range(40, 8));
            md  = 2'($urandom);
            frc = ($urandom_range(5, 0) == 0);
            mk  = DW'($urandom);
            vl  = DW'($urandom) & 8'h0F;
            stream.delete();
            for (int i = 0; i < len; i++) stream.push_back(DW'($urandom) & 8'h0F);
            capture(md, frc, mk, vl, int'($urandom_range(15, 0)), -1);
        end

        // Reset in the middle of a capture returns everything to IDLE
        bus_write(16'h0000, 32'd2);
        bus_write(16'h0004, 32'd9);
        bus_write(16'h0010, 32'd4);
        bus_write(16'h0000, 32'd1);
        cap_valid = 1'b1;
        cap_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #4;
        cap_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < DEPTH; k++) mknown[k] = 1'b0;
        exp_state = 0;
        exp_done  = 1'b0;
        exp_wrap  = 1'b0;
        exp_wptr  = 0;
        exp_tptr  = 0;
        check_all();
        bus_read(16'h0004, 32'd0, 1);
        bus_read(16'h0010, 32'd0, 1);

        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
